mips_mc_control: RTL and testbench
==================================

Name: mips_mc_control

Overview:
- Multicycle main-control FSM for each MIPS core.
- Sequences fetch, decode, execute, memory and writeback for the supported instruction subset.
- Drives datapath enables and muxes, and produces the 2-bit aluop consumed by the ALU decoder: 00 = add, 01 = subtract/compare, 10 = decode funct.
- Waits on a shared-memory ready handshake so both cores can arbitrate one memory port.

Parameters:
- IMPL_ILLEGAL_TRAP, 1, when 1 an undefined opcode sets the sticky illegal_op flag; when 0 it is silently treated as a NOP.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- opcode  input  6  instr[31:26] from the instruction register.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory/arbiter has completed the current access this cycle.
- iord  output  1  memory address select: 0 = PC, 1 = ALU out.
- memwrite  output  1  memory write strobe.
- irwrite  output  1  instruction register load.
- regdst  output  1  register write address select: 1 = rd, 0 = rt.
- memtoreg  output  1  register write data select: 1 = memory data.
- regwrite  output  1  register file write enable.
- alusrca  output  1  ALU A select: 0 = PC, 1 = register A.
- alusrcb  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- aluop  output  2  to the ALU decoder.
- pcsrc  output  2  PC source: 00 = ALU result, 01 = ALU out, 10 = jump target.
- pcen  output  1  PC load = pcwrite | (branch & zero).
- illegal_op  output  1  sticky undefined-opcode flag.
- state_o  output  4  current state, for debug and the dual-core monitor.

Behaviour:
- Reset: while rst_n is low, state = FETCH (0) and illegal_op = 0. Every write enable (memwrite, irwrite, regwrite, pcen) is forced to 0. All other outputs show the FETCH decode.
- Outputs are Moore decodes of state; only the memory-gated strobes also depend on mem_ready. Any output not listed for a state is 0.
- Opcodes: R-type 000000, lb 100000, sb 101000, beq 000100, addi 001000, j 000010.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, ALUWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11, BNEEX 12 (only with the optional feature).
- FETCH:
  - Outputs: iord = 0, alusrcb = 01, aluop = 00, pcsrc = 00.
  - irwrite and pcwrite are asserted only in the cycle where mem_ready = 1.
  - Stays in FETCH while mem_ready = 0; goes to DECODE on mem_ready = 1.
- DECODE:
  - Outputs: alusrcb = 11, aluop = 00 (branch target computed).
  - Next state: lb/sb -> MEMADR, R-type -> RTYPEEX, beq -> BEQEX, addi -> ADDIEX, j -> JEX.
  - Any other opcode -> FETCH; illegal_op is set if IMPL_ILLEGAL_TRAP = 1.
- MEMADR: alusrca = 1, alusrcb = 10, aluop = 00. Next: lb -> MEMRD, sb -> MEMWR.
- MEMRD: iord = 1. Holds until mem_ready = 1, then -> MEMWB.
- MEMWB: memtoreg = 1, regdst = 0, regwrite = 1. Next -> FETCH.
- MEMWR:
  - iord = 1, memwrite = 1, held until mem_ready = 1, then -> FETCH.
  - memwrite stays high for every cycle spent in MEMWR.
- RTYPEEX: alusrca = 1, alusrcb = 00, aluop = 10. Next -> ALUWB.
- ALUWB: regdst = 1, memtoreg = 0, regwrite = 1. Next -> FETCH.
- BEQEX: alusrca = 1, alusrcb = 00, aluop = 01, pcsrc = 01, branch = 1. Next -> FETCH.
- ADDIEX: alusrca = 1, alusrcb = 10, aluop = 00. Next -> ADDIWB.
- ADDIWB: regdst = 0, memtoreg = 0, regwrite = 1. Next -> FETCH.
- JEX: pcsrc = 10, pcwrite = 1. Next -> FETCH.
- Unreachable state encodings (13-15, or 12 without the feature) -> FETCH next cycle with all outputs 0.
- Cycle counts with mem_ready tied high:
  - R-type, addi, lb (lb = 5): 4 cycles, except lb.
  - sb, beq, j: sb = 4, beq = 3, j = 3.
- Reset asserted mid-instruction aborts immediately. No partial write completes after rst_n falls.
- illegal_op clears only on reset.

Optional Feature:
- Macro MC_BNE_EN.
- When defined: opcode 000101 (bne) decodes to BNEEX. BNEEX matches BEQEX except the PC load term is branch & ~zero; pcen = pcwrite | (branch & zero) | (branchne & ~zero).
- When undefined: 000101 is an undefined opcode, handled exactly as any other undefined opcode.

Test Plan:
- Reset, then rst_n high with mem_ready = 0 for 3 cycles -> state_o stays 0 and irwrite = pcen = 0; mem_ready = 1 -> irwrite = pcen = 1 for one cycle, then state_o = 1.
- R-type opcode 000000, mem_ready = 1 -> states 0,1,6,7 then 0; aluop = 10 in state 6; regwrite = 1 and regdst = 1 only in state 7.
- lb 100000 with mem_ready low for 2 cycles in MEMRD -> states 0,1,2,3,3,3,4; regwrite = 1 with memtoreg = 1 only in state 4; iord = 1 in all cycles of state 3.
- beq 000100 with zero = 1 -> pcen = 1 in BEQEX with pcsrc = 01, aluop = 01; repeat with zero = 0 -> pcen = 0.
- Opcode 111111 -> DECODE then FETCH, illegal_op = 1 and sticky; regwrite and memwrite never asserted; reset clears illegal_op.
- With MC_BNE_EN defined, opcode 000101 and zero = 0 -> state 12, pcen = 1; without the macro, the same opcode sets illegal_op.

Source files
------------

// File: rtl/mips_mc_control.sv
// Multicycle main-control FSM for a MIPS core: sequences fetch/decode/execute/memory/writeback.
// Optional bne support is compiled in when the macro MC_BNE_EN is defined.
module mips_mc_control #(
   parameter bit IMPL_ILLEGAL_TRAP = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] aluop,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic       illegal_op,
   output logic [3:0] state_o
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_ALUWB   = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11,
      S_BNEEX   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BNE   = 6'b000101;

   state_t state_q, state_d;
   logic   illegal_q, illegal_d;
   logic   pcwrite, branch, branchne;
   logic   memwrite_s, irwrite_s, regwrite_s;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   // NOTE: every output and next-state term gets a default first, so no path infers a latch.
   always_comb begin
      state_d    = S_FETCH;
      illegal_d  = illegal_q;
      iord       = 1'b0;
      memwrite_s = 1'b0;
      irwrite_s  = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      regwrite_s = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      aluop      = 2'b00;
      pcsrc      = 2'b00;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      branchne   = 1'b0;

      case (state_q)
         S_FETCH: begin
            alusrcb   = 2'b01;
            irwrite_s = mem_ready;
            pcwrite   = mem_ready;
            state_d   = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (opcode)
               OP_LB, OP_SB: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTYPEEX;
               OP_BEQ:       state_d = S_BEQEX;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JEX;
`ifdef MC_BNE_EN
               OP_BNE:       state_d = S_BNEEX;
`endif
               default: begin
                  state_d = S_FETCH;
                  if (IMPL_ILLEGAL_TRAP) illegal_d = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = (opcode == OP_SB) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            iord    = 1'b1;
            state_d = mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            memtoreg   = 1'b1;
            regwrite_s = 1'b1;
         end
         S_MEMWR: begin
            iord       = 1'b1;
            memwrite_s = 1'b1;
            state_d    = mem_ready ? S_FETCH : S_MEMWR;
         end
         S_RTYPEEX: begin
            alusrca = 1'b1;
            aluop   = 2'b10;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            regdst     = 1'b1;
            regwrite_s = 1'b1;
         end
         S_BEQEX: begin
            alusrca = 1'b1;
            aluop   = 2'b01;
            pcsrc   = 2'b01;
            branch  = 1'b1;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: regwrite_s = 1'b1;
         S_JEX: begin
            pcsrc   = 2'b10;
            pcwrite = 1'b1;
         end
`ifdef MC_BNE_EN
         S_BNEEX: begin
            alusrca  = 1'b1;
            aluop    = 2'b01;
            pcsrc    = 2'b01;
            branchne = 1'b1;
         end
`endif
         default: state_d = S_FETCH;
      endcase
   end

   // Write enables are gated by rst_n so nothing is written while reset is held.
   assign memwrite   = rst_n & memwrite_s;
   assign irwrite    = rst_n & irwrite_s;
   assign regwrite   = rst_n & regwrite_s;
   assign pcen       = rst_n & (pcwrite | (branch & zero) | (branchne & ~zero));
   assign illegal_op = illegal_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_mips_mc_control.sv
// Table-driven bench for mips_mc_control plus hand sequences for the memory-wait corners.
module tb_mips_mc_control;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, zero, mem_ready;
   logic [5:0] opcode;
   logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal_op;
   logic [1:0] alusrcb, aluop, pcsrc;
   logic [3:0] state_o;

   logic       n_iord, n_memwrite, n_irwrite, n_regdst, n_memtoreg, n_regwrite, n_alusrca, n_pcen, n_illegal;
   logic [1:0] n_alusrcb, n_aluop, n_pcsrc;
   logic [3:0] n_state;

   mips_mc_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
      .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
      .aluop(aluop), .pcsrc(pcsrc), .pcen(pcen), .illegal_op(illegal_op), .state_o(state_o)
   );

   // Same stimulus, trap disabled: undefined opcodes must never raise the flag.
   mips_mc_control #(.IMPL_ILLEGAL_TRAP(1'b0)) dut_nt (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .iord(n_iord), .memwrite(n_memwrite), .irwrite(n_irwrite), .regdst(n_regdst),
      .memtoreg(n_memtoreg), .regwrite(n_regwrite), .alusrca(n_alusrca), .alusrcb(n_alusrcb),
      .aluop(n_aluop), .pcsrc(n_pcsrc), .pcen(n_pcen), .illegal_op(n_illegal), .state_o(n_state)
   );

   localparam logic [5:0] RT = 6'b000000, LB = 6'b100000, SB = 6'b101000, BEQ = 6'b000100;
   localparam logic [5:0] ADDI = 6'b001000, JMP = 6'b000010, BAD = 6'b111111, BNE = 6'b000101;

   // Layout: {iord,memwrite,irwrite,regdst,memtoreg,regwrite,alusrca}_alusrcb_aluop_pcsrc_pcen
   localparam logic [13:0] O_F0   = 14'b0000000_01_00_00_0;
   localparam logic [13:0] O_F1   = 14'b0010000_01_00_00_1;
   localparam logic [13:0] O_DEC  = 14'b0000000_11_00_00_0;
   localparam logic [13:0] O_MADR = 14'b0000001_10_00_00_0;
   localparam logic [13:0] O_MRD  = 14'b1000000_00_00_00_0;
   localparam logic [13:0] O_MWB  = 14'b0000110_00_00_00_0;
   localparam logic [13:0] O_MWR  = 14'b1100000_00_00_00_0;
   localparam logic [13:0] O_REX  = 14'b0000001_00_10_00_0;
   localparam logic [13:0] O_AWB  = 14'b0001010_00_00_00_0;
   localparam logic [13:0] O_BR0  = 14'b0000001_00_01_01_0;
   localparam logic [13:0] O_BR1  = 14'b0000001_00_01_01_1;
   localparam logic [13:0] O_AEX  = 14'b0000001_10_00_00_0;
   localparam logic [13:0] O_IWB  = 14'b0000010_00_00_00_0;
   localparam logic [13:0] O_JEX  = 14'b0000000_00_00_10_1;

   typedef struct {
      logic        rst_n;
      logic [5:0]  op;
      logic        zero;
      logic        rdy;
      logic [3:0]  st;
      logic [14:0] outs;
   } vec_t;

   vec_t vecs[$];
   int   tests = 0;
   int   fails = 0;

   task automatic add(input logic r, input logic [5:0] op, input logic z, input logic rdy,
                      input logic [3:0] st, input logic [13:0] o, input logic ill);
      vec_t v;
      v.rst_n = r; v.op = op; v.zero = z; v.rdy = rdy; v.st = st; v.outs = {o, ill};
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic [5:0] op, input logic z, input logic rdy);
      @(negedge clk);
      opcode = op; zero = z; mem_ready = rdy;
      #1;
   endtask

   function automatic logic [14:0] dut_outs();
      return {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
              alusrcb, aluop, pcsrc, pcen, illegal_op};
   endfunction

   initial begin
      rst_n = 1'b0; opcode = RT; zero = 1'b0; mem_ready = 1'b0;

      // Reset with mem_ready high: enables still forced low.
      add(0, RT, 0, 1, 0, O_F0, 0);
      add(1, RT, 0, 0, 0, O_F0, 0);
      add(1, RT, 0, 0, 0, O_F0, 0);
      add(1, RT, 0, 0, 0, O_F0, 0);
      // R-type: 0,1,6,7
      add(1, RT, 0, 1, 0, O_F1, 0);
      add(1, RT, 0, 1, 1, O_DEC, 0);
      add(1, RT, 0, 1, 6, O_REX, 0);
      add(1, RT, 0, 1, 7, O_AWB, 0);
      // lb with two wait cycles in MEMRD: 0,1,2,3,3,3,4
      add(1, LB, 0, 1, 0, O_F1, 0);
      add(1, LB, 0, 1, 1, O_DEC, 0);
      add(1, LB, 0, 1, 2, O_MADR, 0);
      add(1, LB, 0, 0, 3, O_MRD, 0);
      add(1, LB, 0, 0, 3, O_MRD, 0);
      add(1, LB, 0, 1, 3, O_MRD, 0);
      add(1, LB, 0, 1, 4, O_MWB, 0);
      // sb with one wait cycle in MEMWR
      add(1, SB, 0, 1, 0, O_F1, 0);
      add(1, SB, 0, 1, 1, O_DEC, 0);
      add(1, SB, 0, 1, 2, O_MADR, 0);
      add(1, SB, 0, 0, 5, O_MWR, 0);
      add(1, SB, 0, 1, 5, O_MWR, 0);
      // beq taken, then not taken
      add(1, BEQ, 1, 1, 0, O_F1, 0);
      add(1, BEQ, 1, 1, 1, O_DEC, 0);
      add(1, BEQ, 1, 1, 8, O_BR1, 0);
      add(1, BEQ, 0, 1, 0, O_F1, 0);
      add(1, BEQ, 0, 1, 1, O_DEC, 0);
      add(1, BEQ, 0, 1, 8, O_BR0, 0);
      // addi, j
      add(1, ADDI, 0, 1, 0, O_F1, 0);
      add(1, ADDI, 0, 1, 1, O_DEC, 0);
      add(1, ADDI, 0, 1, 9, O_AEX, 0);
      add(1, ADDI, 0, 1, 10, O_IWB, 0);
      add(1, JMP, 0, 1, 0, O_F1, 0);
      add(1, JMP, 0, 1, 1, O_DEC, 0);
      add(1, JMP, 0, 1, 11, O_JEX, 0);
      // Undefined opcode: flag appears after DECODE and stays through a later R-type
      add(1, BAD, 0, 1, 0, O_F1, 0);
      add(1, BAD, 0, 1, 1, O_DEC, 0);
      add(1, RT, 0, 0, 0, O_F0, 1);
      add(1, RT, 0, 1, 0, O_F1, 1);
      add(1, RT, 0, 1, 1, O_DEC, 1);
      add(1, RT, 0, 1, 6, O_REX, 1);
      add(1, RT, 0, 1, 7, O_AWB, 1);
      // sb aborted by reset in MEMWR: memwrite drops at once and the flag clears
      add(1, SB, 0, 1, 0, O_F1, 1);
      add(1, SB, 0, 1, 1, O_DEC, 1);
      add(1, SB, 0, 1, 2, O_MADR, 1);
      add(1, SB, 0, 0, 5, O_MWR, 1);
      add(0, SB, 0, 1, 0, O_F0, 0);
      add(1, SB, 0, 0, 0, O_F0, 0);
      // bne
      add(1, BNE, 0, 1, 0, O_F1, 0);
      add(1, BNE, 0, 1, 1, O_DEC, 0);
`ifdef MC_BNE_EN
      add(1, BNE, 0, 1, 12, O_BR1, 0);
      add(1, BNE, 1, 0, 0, O_F0, 0);
`else
      add(1, BNE, 0, 0, 0, O_F0, 1);
`endif

      foreach (vecs[i]) begin
         @(negedge clk);
         rst_n = vecs[i].rst_n; opcode = vecs[i].op; zero = vecs[i].zero; mem_ready = vecs[i].rdy;
         #1;
         check($sformatf("vec%0d state", i), {28'd0, state_o}, {28'd0, vecs[i].st});
         check($sformatf("vec%0d outs", i), {17'd0, dut_outs()}, {17'd0, vecs[i].outs});
         check($sformatf("vec%0d notrap_illegal", i), {31'd0, n_illegal}, 32'd0);
      end

      // Long MEMWR wait: memwrite held every cycle until mem_ready.
      @(negedge clk); rst_n = 1'b0; #1;
      @(negedge clk); rst_n = 1'b1;
      step(SB, 0, 1);
      step(SB, 0, 0);
      step(SB, 0, 0);
      for (int k = 0; k < 5; k++) begin
         step(SB, 0, 0);
         check($sformatf("memwr_wait%0d state", k), {28'd0, state_o}, 32'd5);
         check($sformatf("memwr_wait%0d memwrite", k), {30'd0, memwrite, iord}, 32'd3);
      end
      step(SB, 0, 1);
      check("memwr_last memwrite", {31'd0, memwrite}, 32'd1);
      step(SB, 0, 0);
      check("memwr_exit state", {28'd0, state_o}, 32'd0);

      // Bounded wait for DECODE once memory is ready.
      begin
         int cyc = 0;
         while (state_o != 4'd1 && cyc < 4) begin
            step(RT, 0, 1);
            cyc++;
         end
         check("fetch_to_decode within bound", {31'd0, (state_o == 4'd1)}, 32'd1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
